updown_counter_param: RTL
=========================

// Module: updown_counter_param
// PURPOSE
//  Parametrised up/down counter with synchronous load, programmable modulus, step size and
//  wrap/saturate mode. Next generation of the team's fixed 4-bit load/up-down counter.
//  Adds terminal-count pulse, sticky wrap flag and boundary decodes for cascading/display.
//  Sits between front-panel controls (count, up_down, load) and downstream display/logic.
// PARAMETERS
//  WIDTH      4              counter width in bits (1..32)
//  MAX_VALUE  (1<<WIDTH)-1   highest count; range is 0..MAX_VALUE (1 <= MAX_VALUE <= 2^WIDTH-1)
//  STEP       1              increment/decrement per enabled cycle (1..MAX_VALUE)
//  SATURATE   0              0 = wrap modulo MAX_VALUE+1; 1 = clamp at 0 / MAX_VALUE
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  reset       in   1      synchronous, active-high reset
//  count       in   1      count enable (one step per cycle while high)
//  up_down     in   1      1 = count up, 0 = count down
//  load        in   1      synchronous load of load_input
//  load_input  in   WIDTH  load value
//  value       out  WIDTH  current count (registered)
//  tc          out  1      one-cycle pulse: boundary crossed/hit on this step
//  wrapped     out  1      sticky: at least one wrap or saturation event since reset/load
//  at_max      out  1      value == MAX_VALUE (decode of value register)
//  at_min      out  1      value == 0 (decode of value register)
// BEHAVIOUR
//  - Priority per cycle: reset > load > count. up_down ignored unless counting.
//  - Reset: value=0, tc=0, wrapped=0 next cycle (at_min=1, at_max=0). Reset mid-count wins.
//  - Load: value <= min(load_input, MAX_VALUE) (clamp out-of-range); tc=0; wrapped=0.
//  - Count up, v+STEP <= MAX_VALUE: value <= v+STEP, tc=0.
//  - Count up, v+STEP >  MAX_VALUE: wrap mode value <= v+STEP-(MAX_VALUE+1);
//    saturate mode value <= MAX_VALUE. tc=1, wrapped<=1. Saturate at MAX_VALUE keeps pulsing tc.
//  - Count down, v >= STEP: value <= v-STEP, tc=0.
//  - Count down, v <  STEP: wrap mode value <= v+(MAX_VALUE+1)-STEP; saturate mode value <= 0;
//    tc=1, wrapped<=1.
//  - Arithmetic in WIDTH+1 bits; no intermediate overflow for any legal parameter set.
//  - count=0 and load=0: value holds, tc=0, wrapped holds.
//  - Latency: value/tc/wrapped registered, updated one cycle after sampled controls.
//    at_max/at_min are combinational decodes of value, valid in same cycle as value.
//  - No FSM beyond counter register; tc is never high on reset or load cycles' results.
// CONFIGURATION
//  COUNT_EDGE_DETECT_EN defined: count passes a 2-flop synchroniser plus rising-edge detector;
//    one step per 0->1 transition of count regardless of high duration; step applied 3 cycles
//    after the rising edge is sampled; up_down sampled on the cycle the step is applied.
//    Reset clears synchroniser and edge flops; a load coinciding with the internal pulse wins
//    and the pulse is discarded.
//  Not defined: count is a level enable used directly, one step per cycle while high.
// TESTING  (WIDTH=4, MAX_VALUE=9, STEP=1, SATURATE=0 unless stated)
//  1. reset=1 1 cycle -> value=0, at_min=1, tc=0, wrapped=0; reset during counting -> value=0.
//  2. count=1 up_down=1 from 0 for 10 cycles -> 1..9,0; tc=1 only on 9->0; wrapped=1 after.
//  3. count=1 up_down=0 from 0 -> value=9, tc=1; next cycle 8, tc=0.
//  4. load=1 load_input=13 with count=1 -> value=9 (clamped), tc=0, wrapped=0, at_max=1.
//  5. SATURATE=1, STEP=4: up from 7 -> 9, tc=1; again -> 9, tc=1; down from 2 -> 0, tc=1.
//  6. COUNT_EDGE_DETECT_EN: count held high 20 cycles -> exactly one step, 3 cycles after edge.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with synchronous load, modulus, step and wrap/saturate mode.
// Optional build macro COUNT_EDGE_DETECT_EN: count becomes a synchronised rising-edge trigger.
module updown_counter_param #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VALUE = (1 << WIDTH) - 1,
    parameter int unsigned STEP      = 1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_input,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             wrapped,
    output logic             at_max,
    output logic             at_min
);

    // One extra bit of headroom keeps value+STEP and value+MODULUS free of overflow.
    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH + 1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   MODULUS  = MAX_EXT + (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VALUE);

    logic             step_en;
    logic [WIDTH-1:0] value_q;
    logic             tc_q;
    logic             wrapped_q;
    logic [WIDTH-1:0] next_value;
    logic             next_tc;
    logic             next_wrapped;
    logic [WIDTH:0]   value_ext;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   load_ext;

`ifdef COUNT_EDGE_DETECT_EN
    logic count_sync0;
    logic count_sync1;
    logic count_prev;
    logic step_pulse;

    // Two-flop synchroniser, then a registered rising-edge pulse: one step per press.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_sync0 <= 1'b0;
            count_sync1 <= 1'b0;
            count_prev  <= 1'b0;
            step_pulse  <= 1'b0;
        end else begin
            count_sync0 <= count;
            count_sync1 <= count_sync0;
            count_prev  <= count_sync1;
            step_pulse  <= count_sync1 & ~count_prev;
        end
    end

    assign step_en = step_pulse;
`else
    assign step_en = count;
`endif

    always_comb begin
        value_ext    = {1'b0, value_q};
        sum_up       = value_ext + STEP_EXT;
        load_ext     = {1'b0, load_input};
        next_value   = value_q;
        next_tc      = 1'b0;
        next_wrapped = wrapped_q;

        // Load outranks counting, so a coincident step is simply dropped.
        if (load) begin
            next_value   = (load_ext > MAX_EXT) ? MAX_W : load_input;
            next_wrapped = 1'b0;
        end else if (step_en) begin
            if (up_down) begin
                if (sum_up > MAX_EXT) begin
                    next_value   = SATURATE ? MAX_W : WIDTH'(sum_up - MODULUS);
                    next_tc      = 1'b1;
                    next_wrapped = 1'b1;
                end else begin
                    next_value = WIDTH'(sum_up);
                end
            end else begin
                if (value_ext < STEP_EXT) begin
                    next_value   = SATURATE ? '0 : WIDTH'(value_ext + MODULUS - STEP_EXT);
                    next_tc      = 1'b1;
                    next_wrapped = 1'b1;
                end else begin
                    next_value = WIDTH'(value_ext - STEP_EXT);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q   <= '0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            value_q   <= next_value;
            tc_q      <= next_tc;
            wrapped_q <= next_wrapped;
        end
    end

    assign value   = value_q;
    assign tc      = tc_q;
    assign wrapped = wrapped_q;
    assign at_max  = (value_q == MAX_W);
    assign at_min  = (value_q == '0);

endmodule
